uart_tx_fifo: RTL and testbench

//  Byte buffer and launch sequencer upstream of the UART transmitter.

---
 rtl/uart_tx_fifo_if.sv | 26 ++
 rtl/uart_tx_fifo.sv | 120 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Host write port, status flags and transmitter launch handshake for uart_tx_fifo.
// master = host/transmitter side, slave = the FIFO itself.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              ovf_clr;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic [7:0]        TX_DATA;
  logic              TX_start;
  logic              TX_busy;

  modport master (
    output wr_en, wr_data, ovf_clr, TX_busy,
    input  full, empty, count, overflow, TX_DATA, TX_start
  );

  modport slave (
    input  wr_en, wr_data, ovf_clr, TX_busy,
    output full, empty, count, overflow, TX_DATA, TX_start
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter one byte at a time through a
// level-held TX_start / TX_busy handshake.
//
// state     | meaning
// IDLE      | no byte in flight; pop and launch when data queued and tx not busy
// WAIT_BUSY | TX_start held high until the transmitter reports busy
// WAIT_DONE | byte accepted by transmitter; wait for busy to drop
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  state_t              state;
  state_t              state_nxt;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W:0]     count;
  logic [7:0]          tx_data;
  logic                overflow;
  logic                full;
  logic                empty;
  logic                pop;
  logic                push;
  logic                drop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A pop frees a slot at the same edge, so a write into a full FIFO is kept then.
  assign push = bus.wr_en && (!full || pop);
  assign drop = bus.wr_en && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !bus.TX_busy) begin
          pop       = 1'b1;
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (bus.TX_busy) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!bus.TX_busy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      tx_data  <= 8'h00;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        tx_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (bus.ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count;
  assign bus.overflow = overflow;
  assign bus.TX_DATA  = tx_data;
  assign bus.TX_start = (state == WAIT_BUSY);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboarded bench for uart_tx_fifo: directed scenarios then random traffic
// against a queue model, with a behavioural transmitter driving TX_busy.
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clk;
  logic rst;
  logic tx_busy_m;
  logic stall;

  int errors;
  int checks;

  int tx_dly;
  int tx_len;
  bit rand_mode;

  logic [7:0] sb_q[$];
  logic       movf;

  uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  assign bus.TX_busy = tx_busy_m | stall;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a rising TX_start is a launch; the byte must match the oldest expected one.
  logic       mon_prev_start;
  logic       mon_busy_pre;
  logic       mon_rst_pre;
  logic [7:0] mon_held;
  logic [7:0] mon_exp;
  always @(posedge clk) begin
    mon_prev_start = bus.TX_start;
    mon_busy_pre   = bus.TX_busy;
    mon_rst_pre    = rst;
    #1;
    if (mon_rst_pre === 1'b1 && bus.TX_start === 1'b1 && mon_prev_start === 1'b0) begin
      chk("launch_while_busy", {31'd0, mon_busy_pre}, 32'd0);
      if (sb_q.size() == 0) begin
        chk("launch_with_nothing_queued", 32'd1, 32'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("tx_byte", {24'd0, bus.TX_DATA}, {24'd0, mon_exp});
      end
      mon_held = bus.TX_DATA;
    end else if (bus.TX_start === 1'b1 && mon_prev_start === 1'b1) begin
      chk("tx_data_stable", {24'd0, bus.TX_DATA}, {24'd0, mon_held});
    end
  end

  // Reference model: bytes held are exactly the scoreboard queue contents.
  logic       m_wr;
  logic [7:0] m_data;
  logic       m_clr;
  logic       m_rst;
  logic       m_drop;
  always @(posedge clk) begin
    m_wr   = bus.wr_en;
    m_data = bus.wr_data;
    m_clr  = bus.ovf_clr;
    m_rst  = rst;
    #2;
    if (!m_rst) begin
      sb_q.delete();
      movf = 1'b0;
    end else begin
      m_drop = m_wr && (sb_q.size() >= DEPTH);
      if (m_wr && !m_drop) sb_q.push_back(m_data);
      if (m_drop) movf = 1'b1;
      else if (m_clr) movf = 1'b0;
    end
    chk("count", {27'd0, bus.count}, sb_q.size());
    chk("full", {31'd0, bus.full}, {31'd0, sb_q.size() == DEPTH});
    chk("empty", {31'd0, bus.empty}, {31'd0, sb_q.size() == 0});
    chk("overflow", {31'd0, bus.overflow}, {31'd0, movf});
  end

  // Behavioural transmitter: raises busy some cycles after a launch, holds it, releases.
  initial begin : xmit
    int dly;
    int len;
    tx_busy_m = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.TX_start === 1'b1 && !tx_busy_m) begin
        dly = rand_mode ? int'($urandom_range(1, 6)) : tx_dly;
        len = rand_mode ? int'($urandom_range(1, 10)) : tx_len;
        repeat (dly - 1) @(negedge clk);
        tx_busy_m = 1'b1;
        @(posedge clk);
        #1;
        chk("start_drop_on_busy", {31'd0, bus.TX_start}, 32'd0);
        repeat (len) @(negedge clk);
        tx_busy_m = 1'b0;
      end
    end
  end

  task automatic drain(input int lim);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || bus.TX_start || bus.TX_busy) && n < lim) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_timeout", {31'd0, n < lim}, 32'd1);
  endtask

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    bus.wr_en   = 1'b0;
    bus.ovf_clr = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    errors      = 0;
    checks      = 0;
    movf        = 1'b0;
    rand_mode   = 1'b0;
    tx_dly      = 2;
    tx_len      = 3;
    stall       = 1'b0;
    rst         = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hC3;
    bus.ovf_clr = 1'b0;

    // 1: reset held three cycles with wr_en asserted
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count", {27'd0, bus.count}, 32'd0);
    chk("rst_empty", {31'd0, bus.empty}, 32'd1);
    chk("rst_full", {31'd0, bus.full}, 32'd0);
    chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    chk("rst_tx_start", {31'd0, bus.TX_start}, 32'd0);
    chk("rst_tx_data", {24'd0, bus.TX_DATA}, 32'h00);
    bus.wr_en = 1'b0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);

    // 2: single byte latency
    tx_dly = 5;
    tx_len = 4;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hA2;
    @(posedge clk);
    @(negedge clk);
    bus.wr_en = 1'b0;
    chk("lat_start_after_N", {31'd0, bus.TX_start}, 32'd0);
    chk("lat_count_after_N", {27'd0, bus.count}, 32'd1);
    @(posedge clk);
    #1;
    chk("lat_start_after_N1", {31'd0, bus.TX_start}, 32'd1);
    chk("lat_data_after_N1", {24'd0, bus.TX_DATA}, 32'hA2);
    drain(200);

    // 3: burst while transmitter stalled
    tx_dly = 2;
    tx_len = 3;
    @(negedge clk);
    stall = 1'b1;
    for (int i = 1; i <= DEPTH; i++) write_byte(8'(i));
    idle_inputs();
    chk("burst_full", {31'd0, bus.full}, 32'd1);
    chk("burst_count", {27'd0, bus.count}, 32'd16);
    chk("burst_overflow", {31'd0, bus.overflow}, 32'd0);

    // 4: dropped write sets overflow; clear pulse
    write_byte(8'hFF);
    idle_inputs();
    chk("ovf_count", {27'd0, bus.count}, 32'd16);
    chk("ovf_set", {31'd0, bus.overflow}, 32'd1);
    bus.ovf_clr = 1'b1;
    idle_inputs();
    chk("ovf_cleared", {31'd0, bus.overflow}, 32'd0);

    // 5: write accepted in the same cycle as a pop from a full FIFO
    @(negedge clk);
    stall       = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h77;
    @(posedge clk);
    #1;
    chk("fullpop_count", {27'd0, bus.count}, 32'd16);
    chk("fullpop_overflow", {31'd0, bus.overflow}, 32'd0);
    chk("fullpop_start", {31'd0, bus.TX_start}, 32'd1);
    idle_inputs();
    drain(1000);

    // 6: reset in WAIT_DONE with five bytes queued
    tx_dly = 2;
    tx_len = 60;
    for (int i = 0; i < 6; i++) write_byte(8'h30 + 8'(i));
    idle_inputs();
    n = 0;
    while (!(bus.TX_busy && !bus.TX_start && sb_q.size() == 5) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_reach_wait_done", {31'd0, n < 50}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_count", {27'd0, bus.count}, 32'd0);
    chk("midrst_tx_start", {31'd0, bus.TX_start}, 32'd0);
    chk("midrst_empty", {31'd0, bus.empty}, 32'd1);
    tx_len = 3;
    write_byte(8'h5A);
    idle_inputs();
    n = 0;
    while (bus.TX_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_next_launch_seen", {31'd0, n < 200}, 32'd1);
    chk("midrst_next_byte", {24'd0, bus.TX_DATA}, 32'h5A);
    drain(500);

    // random traffic
    rand_mode = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      bus.wr_en   = ($urandom % 3) != 0;
      bus.wr_data = 8'($urandom);
      bus.ovf_clr = ($urandom % 16) == 0;
      if (!bus.TX_start && !tx_busy_m && ($urandom % 30) == 0) stall = ~stall;
    end
    @(negedge clk);
    bus.wr_en   = 1'b0;
    bus.ovf_clr = 1'b0;
    stall       = 1'b0;
    drain(5000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
